uart_echo_buffer: RTL and testbench
===================================

UART_ECHO_BUFFER -- requirements
Module: uart_echo_buffer

Interface
REQ-001 Parameter DATA_W, default 8: width of received/transmitted characters.
REQ-002 Parameter DEPTH, default 16: FIFO entries; SHALL be a power of two, at least 2.
REQ-003 Parameter LF_EXPAND, default 1: when 1, every echoed CR (0x0D) is followed by an inserted LF (0x0A); when 0, bytes are echoed verbatim.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rx_received  in  1  one-cycle pulse from UART receiver: rx_byte is valid.
REQ-007 rx_byte  in  DATA_W  received character.
REQ-008 tx_busy  in  1  UART transmitter is_transmitting status.
REQ-009 tx_start  out  1  one-cycle pulse requesting transmission of tx_byte.
REQ-010 tx_byte  out  DATA_W  character to transmit; stable from the tx_start cycle until tx_busy falls.
REQ-011 fill  out  log2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  out  1  one-cycle pulse when a received byte is dropped.
REQ-013 drop_count  out  8  saturating count of dropped bytes.

Function
REQ-014 Each rx_received pulse SHALL push rx_byte into the FIFO in the same clock edge when the FIFO is not full.
REQ-015 Push with FIFO full and no pop in that cycle: byte is discarded, overflow pulses next cycle, drop_count increments and saturates at 255.
REQ-016 Push and pop in the same cycle with FIFO full: push is accepted and fill is unchanged.
REQ-017 Push and pop in the same cycle with FIFO empty: no bypass; the byte is stored and popped on a later cycle.
REQ-018 Read and write pointers SHALL wrap modulo DEPTH; fill SHALL equal writes minus reads, in the range 0..DEPTH.
REQ-019 The transmit FSM SHALL have states IDLE, START, WAIT_BUSY, WAIT_DONE and INSERT_LF.
REQ-020 IDLE: if fill>0 and tx_busy=0, pop the head into tx_byte and go to START. Otherwise stay in IDLE.
REQ-021 START: assert tx_start for exactly one cycle, then go to WAIT_BUSY.
REQ-022 WAIT_BUSY: remain until tx_busy=1, then go to WAIT_DONE.
REQ-023 WAIT_DONE: remain until tx_busy=0.
REQ-024 On leaving WAIT_DONE: if LF_EXPAND=1, the byte just sent was 0x0D, and no LF has yet been inserted for it, go to INSERT_LF; otherwise go to IDLE.
REQ-025 INSERT_LF: load 0x0A into tx_byte without popping, then go to START; the inserted LF itself SHALL never trigger a further insertion.
REQ-026 Latency: a byte written into an empty FIFO while idle SHALL produce tx_start no earlier than 2 and no later than 3 cycles after the rx_received cycle.
REQ-027 tx_start SHALL never assert while tx_busy=1 or in any state other than START.
REQ-028 When DATA_W≠8, CR/LF comparison and insertion use the low 8 bits; the upper bits are zero on an inserted LF.

Reset
REQ-029 With rst=1 at a clock edge: FSM→IDLE; pointers and fill→0; tx_start=0; tx_byte=0; overflow=0; drop_count=0.
REQ-030 Reset mid-transmission SHALL abandon any pending LF insertion and all buffered bytes.
REQ-031 After reset, the FSM SHALL wait in IDLE for tx_busy=0 before issuing a new tx_start.
REQ-032 rx_received is ignored during any cycle with rst=1.

Structure
REQ-033 Shared package holds the FSM state encoding and the constants ASCII_CR=0x0D and ASCII_LF=0x0A.
REQ-034 The FIFO SHALL be a separate sub-module sync_fifo, parameterised by DATA_W and DEPTH, with push, pop, full, empty and fill ports; uart_echo_buffer instantiates it once.

Verification
REQ-035 Single byte: 0x41 pulsed in, tx_busy modelled 1 for 10 cycles → exactly one tx_start with tx_byte=0x41, within 3 cycles of the rx pulse.
REQ-036 CR expansion (LF_EXPAND=1): bytes 0x0D, 0x42 → tx sequence 0x0D, 0x0A, 0x42. With LF_EXPAND=0 → 0x0D, 0x42.
REQ-037 Overflow (DEPTH=4): hold tx_busy=1 and push 6 bytes → fill=4, two overflow pulses, drop_count=2; after tx_busy is released, the first 4 bytes are echoed in order.
REQ-038 Full plus simultaneous pop: with fill=DEPTH, push in the cycle IDLE pops → byte accepted, fill stays DEPTH, no overflow pulse.
REQ-039 Reset mid-operation: assert rst during WAIT_DONE of a CR with 3 bytes queued → fill=0, no LF inserted, no tx_start until new data arrives.
REQ-040 Saturation: 300 dropped bytes → drop_count=255.

Source files
------------

// File: rtl/uart_echo_buffer_pkg.sv
// Shared definitions for the UART echo buffer: transmit FSM encoding and the
// ASCII line-ending constants used for CR -> CR/LF expansion.
package uart_echo_buffer_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StWaitBusy = 3'd2,
    StWaitDone = 3'd3,
    StInsertLf = 3'd4
  } tx_state_e;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_echo_buffer_sync_fifo.sv
// Single-clock FIFO with occupancy count. A push into a full FIFO is taken
// only when a pop happens in the same cycle; there is no empty-FIFO bypass.
module sync_fifo
  import uart_echo_buffer_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        wdata,
  input  logic                     pop,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [AW:0]       fill_q;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (fill_q == '0);
  assign full    = (fill_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign fill    = fill_q;

  // Pointers are AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   fill_q <= fill_q + 1'b1;
        2'b01:   fill_q <= fill_q - 1'b1;
        default: fill_q <= fill_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/uart_echo_buffer.sv
// Buffers bytes from a UART receiver and echoes them to the transmitter,
// optionally following every CR with an inserted LF.
module uart_echo_buffer
  import uart_echo_buffer_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          LF_EXPAND = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rx_received,
  input  logic [DATA_W-1:0]      rx_byte,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [DATA_W-1:0]      tx_byte,
  output logic [$clog2(DEPTH):0] fill,
  output logic                   overflow,
  output logic [7:0]             drop_count
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic              lf_done_q, lf_done_d;
  logic              overflow_q;
  logic [7:0]        drop_count_q;

  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic [7:0]        tx_low;
  logic              drop;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_received),
    .wdata (rx_byte),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .fill  (fill)
  );

  // CR detection always looks at the low 8 bits of the character.
  if (DATA_W >= 8) begin : g_low_wide
    assign tx_low = tx_byte_q[7:0];
  end else begin : g_low_narrow
    assign tx_low = 8'(tx_byte_q);
  end

  always_comb begin
    state_d   = state_q;
    tx_byte_d = tx_byte_q;
    lf_done_d = lf_done_q;
    pop       = 1'b0;
    tx_start  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty && !tx_busy) begin
          pop       = 1'b1;
          tx_byte_d = fifo_rdata;
          lf_done_d = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        // Never request a transmission while the transmitter reports busy.
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (!tx_busy) begin
          if (LF_EXPAND && (tx_low == ASCII_CR) && !lf_done_q) begin
            state_d = StInsertLf;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StInsertLf: begin
        tx_byte_d = DATA_W'(ASCII_LF);
        lf_done_d = 1'b1;
        state_d   = StStart;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign drop = rx_received && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      tx_byte_q    <= '0;
      lf_done_q    <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      state_q    <= state_d;
      tx_byte_q  <= tx_byte_d;
      lf_done_q  <= lf_done_d;
      overflow_q <= drop;
      if (drop && (drop_count_q != 8'hFF)) begin
        drop_count_q <= drop_count_q + 8'd1;
      end
    end
  end

  assign tx_byte    = tx_byte_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_uart_echo_buffer.sv
// Directed bench: two echo buffers (LF expansion on and off) driven by the same
// receive stream, each with its own modelled transmitter busy window.
module tb_uart_echo_buffer;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 4;
  localparam int          BUSY_LEN = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              rx_received = 1'b0;
  logic [DATA_W-1:0] rx_byte = '0;
  logic              hold_busy = 1'b0;

  logic              tx_busy_a, tx_busy_b;
  logic              tx_start_a, tx_start_b;
  logic [DATA_W-1:0] tx_byte_a, tx_byte_b;
  logic [2:0]        fill_a, fill_b;
  logic              overflow_a, overflow_b;
  logic [7:0]        drop_count_a, drop_count_b;

  int cnt_a = 0;
  int cnt_b = 0;
  int cyc = 0;
  int first_cyc_a = -1;
  int ov_a = 0;
  int n_checks = 0;
  int n_fails = 0;
  logic [7:0] log_a[$];
  logic [7:0] log_b[$];

  always #5 clk = ~clk;

  uart_echo_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .LF_EXPAND (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_received (rx_received),
    .rx_byte     (rx_byte),
    .tx_busy     (tx_busy_a),
    .tx_start    (tx_start_a),
    .tx_byte     (tx_byte_a),
    .fill        (fill_a),
    .overflow    (overflow_a),
    .drop_count  (drop_count_a)
  );

  uart_echo_buffer #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .LF_EXPAND (1'b0)
  ) dut_raw (
    .clk         (clk),
    .rst         (rst),
    .rx_received (rx_received),
    .rx_byte     (rx_byte),
    .tx_busy     (tx_busy_b),
    .tx_start    (tx_start_b),
    .tx_byte     (tx_byte_b),
    .fill        (fill_b),
    .overflow    (overflow_b),
    .drop_count  (drop_count_b)
  );

  // Transmitter model: busy for BUSY_LEN cycles after each tx_start.
  assign tx_busy_a = hold_busy || (cnt_a != 0);
  assign tx_busy_b = hold_busy || (cnt_b != 0);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (tx_start_a) cnt_a <= BUSY_LEN;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    if (tx_start_b) cnt_b <= BUSY_LEN;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_seq(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
    logic [7:0] g;
    check_eq({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      g = (i < got.size()) ? got[i] : 8'hxx;
      check_eq(tag, {24'h0, g}, {24'h0, exp[i]});
    end
  endtask

  always @(negedge clk) begin
    if (tx_start_a) begin
      log_a.push_back(tx_byte_a);
      if (first_cyc_a < 0) first_cyc_a = cyc;
      check_eq("start_while_busy_a", {31'h0, tx_busy_a}, 32'h0);
    end
    if (tx_start_b) begin
      log_b.push_back(tx_byte_b);
      check_eq("start_while_busy_b", {31'h0, tx_busy_b}, 32'h0);
    end
    if (overflow_a) ov_a++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte     = b;
    rx_received = 1'b1;
    tick(1);
    rx_received = 1'b0;
  endtask

  task automatic clear_logs();
    log_a.delete();
    log_b.delete();
    first_cyc_a = -1;
    ov_a = 0;
  endtask

  initial begin
    int rx_cyc;
    // Reset, with a receive pulse that must be ignored while rst is high.
    rst = 1'b1;
    tick(1);
    rx_byte = 8'h77;
    rx_received = 1'b1;
    tick(1);
    rx_received = 1'b0;
    check_eq("rst_fill", {29'h0, fill_a}, 32'd0);
    check_eq("rst_tx_start", {31'h0, tx_start_a}, 32'd0);
    check_eq("rst_tx_byte", {24'h0, tx_byte_a}, 32'd0);
    check_eq("rst_overflow", {31'h0, overflow_a}, 32'd0);
    check_eq("rst_drop_count", {24'h0, drop_count_a}, 32'd0);
    rst = 1'b0;
    tick(5);
    check_eq("rst_rx_ignored", {29'h0, fill_a}, 32'd0);
    check_seq("rst_no_tx", log_a, '{});

    // Single byte with latency window.
    clear_logs();
    rx_cyc = cyc;
    send(8'h41);
    tick(30);
    check_seq("single", log_a, '{8'h41});
    check_eq("latency_in_2_3",
             {31'h0, (first_cyc_a - rx_cyc >= 2) && (first_cyc_a - rx_cyc <= 3)}, 32'd1);

    // CR expansion on and off.
    clear_logs();
    send(8'h0D);
    send(8'h42);
    tick(70);
    check_seq("cr_expand", log_a, '{8'h0D, 8'h0A, 8'h42});
    check_seq("cr_verbatim", log_b, '{8'h0D, 8'h42});

    // Overflow: six pushes into a four-entry FIFO while the transmitter is busy.
    clear_logs();
    hold_busy = 1'b1;
    for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
    tick(2);
    check_eq("ovf_fill", {29'h0, fill_a}, 32'd4);
    check_eq("ovf_pulses", ov_a, 32'd2);
    check_eq("ovf_drop_count", {24'h0, drop_count_a}, 32'd2);
    hold_busy = 1'b0;
    tick(100);
    check_seq("ovf_echo", log_a, '{8'h10, 8'h11, 8'h12, 8'h13});

    // Full FIFO plus a push in the same cycle IDLE pops.
    clear_logs();
    hold_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(8'h20 + 8'(i));
    hold_busy = 1'b0;
    send(8'h24);
    check_eq("full_pop_fill", {29'h0, fill_a}, 32'd4);
    tick(2);
    check_eq("full_pop_no_ovf", ov_a, 32'd0);
    check_eq("full_pop_drops", {24'h0, drop_count_a}, 32'd2);
    tick(100);
    check_seq("full_pop_echo", log_a, '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24});

    // Reset while the CR is in WAIT_DONE with three bytes still queued.
    clear_logs();
    send(8'h0D);
    send(8'h31);
    send(8'h32);
    send(8'h33);
    tick(4);
    check_eq("pre_rst_fill", {29'h0, fill_a}, 32'd3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_eq("mid_rst_fill", {29'h0, fill_a}, 32'd0);
    check_eq("mid_rst_drops", {24'h0, drop_count_a}, 32'd0);
    tick(40);
    check_seq("mid_rst_no_lf", log_a, '{8'h0D});
    send(8'h55);
    tick(30);
    check_seq("mid_rst_new", log_a, '{8'h0D, 8'h55});

    // Drop counter saturation.
    clear_logs();
    hold_busy = 1'b1;
    for (int i = 0; i < 4 + 254; i++) send(8'(i));
    tick(2);
    check_eq("sat_254", {24'h0, drop_count_a}, 32'd254);
    for (int i = 0; i < 46; i++) send(8'(i));
    tick(2);
    check_eq("sat_255", {24'h0, drop_count_a}, 32'd255);
    check_eq("sat_fill", {29'h0, fill_a}, 32'd4);
    check_eq("sat_pulses", ov_a, 32'd300);
    hold_busy = 1'b0;
    tick(80);
    check_seq("sat_echo", log_a, '{8'h00, 8'h01, 8'h02, 8'h03});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
